// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for uart_tx_arbiter: byte width, default tag prefix and FSM encoding.
// Defining UART_TX_ARB_TAG_EN adds the TAG_ISSUE state.
package uart_pkg;
  localparam int DATA_W = 8;
  localparam logic [3:0] TAG_PREFIX_DEF = 4'hA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3
`ifdef UART_TX_ARB_TAG_EN
    , TAG_ISSUE = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of uart_tx_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/transmitter side.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  import uart_pkg::*;
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_send;
  logic                      tx_busy;
  logic [GW-1:0]             grant_id;
  logic                      arb_busy;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_send, grant_id, arb_busy
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_send, grant_id, arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker; the search starts at the requester
// after i_last_grant and wraps from NUM_REQ-1 to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_last_grant,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GW-1:0]      o_grant_idx,
  output logic               o_valid
);
  int   w_cand;
  logic w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_cand      = 0;
    w_found     = 1'b0;
    if (i_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = int'(i_last_grant) + k;
        if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
        if (!w_found && i_req[w_cand[GW-1:0]]) begin
          w_found                  = 1'b1;
          o_grant[w_cand[GW-1:0]]  = 1'b1;
          o_grant_idx              = w_cand[GW-1:0];
        end
      end
      o_valid = w_found;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// Optional macro UART_TX_ARB_TAG_EN prefixes each byte with a {TAG_PREFIX, grant_id} tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] TAG_PREFIX = TAG_PREFIX_DEF
) (
  input logic            clk,
  input logic            reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_hold;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_last;
  logic                r_tag_phase;

  logic                w_en;
  logic                w_valid;
  logic                w_send;
  logic [NUM_REQ-1:0]  w_grant;
  logic [GW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_sel;
  logic [DATA_W-1:0]   w_tag_byte;

  // Gating with reset keeps req_ready low while reset is held.
  assign w_en = (r_state == IDLE) && !bus.tx_busy && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last),
    .i_en         (w_en),
    .o_grant      (w_grant),
    .o_grant_idx  (w_idx),
    .o_valid      (w_valid)
  );

  assign w_sel      = bus.req_data[{w_idx, 3'b000} +: DATA_W];
  assign w_tag_byte = {TAG_PREFIX, 4'(r_grant)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_send = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
`ifdef UART_TX_ARB_TAG_EN
          w_next = TAG_ISSUE;
`else
          w_next = ISSUE;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      TAG_ISSUE: begin
        w_send = 1'b1;
        w_next = WAIT_HI;
      end
`endif
      ISSUE: begin
        w_send = 1'b1;
        w_next = WAIT_HI;
      end
      WAIT_HI: if (bus.tx_busy) w_next = WAIT_LO;
      // After the tag byte completes, the data byte follows without re-arbitration.
      WAIT_LO: if (!bus.tx_busy) w_next = r_tag_phase ? ISSUE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_grant     <= '0;
      r_last      <= GW'(NUM_REQ - 1);
      r_tag_phase <= 1'b0;
    end else if (w_valid) begin
      r_hold  <= w_sel;
      r_grant <= w_idx;
      r_last  <= w_idx;
`ifdef UART_TX_ARB_TAG_EN
      r_tag_phase <= 1'b1;
`endif
    end else if (r_state == WAIT_LO && !bus.tx_busy) begin
      r_tag_phase <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.tx_send   = w_send;
  assign bus.tx_data   = r_tag_phase ? w_tag_byte : r_hold;
  assign bus.grant_id  = r_grant;
  assign bus.arb_busy  = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters and transmitter.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TAG_PREFIX(4'hA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: an arbiter is either free or owns a byte sequence being sent
  bit          m_free, m_send, m_whi, m_wlo;
  logic [7:0]  m_txd;
  int          m_gid, m_last;
  logic [7:0]  m_q[$];

  // inputs seen at the coming edge and the acceptance they cause
  bit          s_acc, s_busy;
  int          s_win;
  logic [7:0]  s_data;

  // transmitter emulation
  int cyc = 0, bs = 0, be = 0, fcnt = 0;
  bit rand_uart = 0, foreign_en = 0;

  int         g_log[$];
  logic [7:0] s_log[$];

  logic [N-1:0]   v;
  logic [8*N-1:0] d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gl(input int i);
    return (i < g_log.size()) ? g_log[i] : -1;
  endfunction

  function automatic int sl(input int i);
    return (i < s_log.size()) ? int'(s_log[i]) : -1;
  endfunction

  function automatic void model_reset();
    m_free = 1; m_send = 0; m_whi = 0; m_wlo = 0;
    m_txd = 8'h00; m_gid = 0; m_last = N - 1;
    m_q.delete();
    s_acc = 0; s_busy = 0; s_win = 0; s_data = 8'h00;
  endfunction

  function automatic void model_update();
    if (m_wlo) begin
      if (!s_busy) begin
        m_wlo = 0;
        if (m_q.size() > 0) begin
          m_txd  = m_q.pop_front();
          m_send = 1;
        end else begin
          m_free = 1;
        end
      end
    end else if (m_whi) begin
      if (s_busy) begin m_whi = 0; m_wlo = 1; end
    end else if (m_send) begin
      m_send = 0; m_whi = 1;
    end else if (s_acc) begin
      m_free = 0; m_last = s_win; m_gid = s_win; m_send = 1;
`ifdef UART_TX_ARB_TAG_EN
      m_txd = {4'hA, 4'(s_win)};
      m_q.push_back(s_data);
`else
      m_txd = s_data;
`endif
    end
  endfunction

  task automatic drive_and_check(input logic [N-1:0] iv, input logic [8*N-1:0] id, input bit ib);
    logic [N-1:0] exp_ready;
    bus.req_valid = iv;
    bus.req_data  = id;
    bus.tx_busy   = ib;
    #1;
    exp_ready = '0;
    s_acc = 0;
    if (m_free && !ib) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!s_acc && iv[c]) begin s_acc = 1; s_win = c; end
      end
    end
    if (s_acc) begin
      exp_ready[s_win] = 1'b1;
      s_data = id[8*s_win +: 8];
    end
    s_busy = ib;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("tx_send",   32'(bus.tx_send),   32'(m_send));
    chk("tx_data",   32'(bus.tx_data),   32'(m_txd));
    chk("grant_id",  32'(bus.grant_id),  32'(m_gid));
    chk("arb_busy",  32'(bus.arb_busy),  32'(!m_free));
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) g_log.push_back(i);
    if (bus.tx_send) s_log.push_back(bus.tx_data);
  endtask

  // one clock cycle; fb < 0 lets the emulated transmitter drive tx_busy
  task automatic step(input logic [N-1:0] iv, input logic [8*N-1:0] id, input int fb);
    bit b;
    @(posedge clk);
    #1;
    model_update();
    cyc++;
    if (foreign_en && m_free && cyc >= be && fcnt == 0 && ($urandom % 30) == 0)
      fcnt = 1 + int'($urandom % 3);
    b = (fb >= 0) ? fb[0] : ((cyc >= bs && cyc < be) || fcnt > 0);
    drive_and_check(iv, id, b);
    if (bus.tx_send) begin
      bs = cyc + 1 + (rand_uart ? int'($urandom % 3) : 0);
      be = bs + (rand_uart ? 1 + int'($urandom % 4) : 2);
    end
    if (fcnt > 0) fcnt--;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    #1;
    model_reset();
    bs = 0; be = 0; fcnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_tx_send",   32'(bus.tx_send),   0);
    chk("rst_tx_data",   32'(bus.tx_data),   0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_grant_id",  32'(bus.grant_id),  0);
    chk("rst_arb_busy",  32'(bus.arb_busy),  0);

    // single requester, one-cycle latency, no resend while transmitter idle
    d = {24'h0, 8'h55};
    step(4'b0001, d, 0);
    chk("r033_ready", 32'(bus.req_ready), 32'h1);
    step(4'b0000, d, 0);
    chk("r033_send", 32'(bus.tx_send), 1);
    chk("r033_data", 32'(bus.tx_data), 32'h55);
    repeat (3) begin
      step(4'b0000, d, 0);
      chk("r033_nosend", 32'(bus.tx_send), 0);
    end
    step(4'b0000, d, 1);
    step(4'b0000, d, 1);
    step(4'b0000, d, 0);
    step(4'b0000, d, 0);
    chk("r033_idle", 32'(bus.arb_busy), 0);

    // all requesters held: round-robin order from reset
    do_reset();
    g_log.delete(); s_log.delete();
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (22) step(4'b1111, d, -1);
    repeat (10) step(4'b0000, d, -1);
    chk("r034_ngrant", 32'(g_log.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      chk("r034_grant", 32'(gl(i)), 32'(i % 4));
      chk("r034_data",  32'(sl(i)), 32'(8'h10 + (i % 4)));
    end

    // wrap-around after requester 2
    repeat (6) step(4'b0100, d, -1);
    repeat (10) step(4'b0000, d, -1);
    g_log.delete();
    repeat (12) step(4'b0101, d, -1);
    repeat (10) step(4'b0000, d, -1);
    chk("r035_first",  32'(gl(0)), 0);
    chk("r035_second", 32'(gl(1)), 2);

    // foreign use of the transmitter blocks acceptance
    g_log.delete();
    repeat (3) begin
      step(4'b0010, d, 1);
      chk("r038_blocked", 32'(bus.req_ready), 0);
    end
    step(4'b0010, d, 0);
    chk("r038_grant", 32'(bus.req_ready), 32'h2);
    repeat (10) step(4'b0000, d, -1);

    // reset during WAIT_LO aborts the byte
    d = {8'h00, 8'hC3, 16'h0};
    step(4'b0100, d, 0);
    step(4'b0000, d, 0);
    step(4'b0000, d, 1);
    step(4'b0000, d, 1);
    chk("r036_inwait", 32'(bus.arb_busy), 1);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.tx_busy   = 1'b0;
    #1;
    chk("r036_tx_send",   32'(bus.tx_send),   0);
    chk("r036_tx_data",   32'(bus.tx_data),   0);
    chk("r036_req_ready", 32'(bus.req_ready), 0);
    chk("r036_grant_id",  32'(bus.grant_id),  0);
    chk("r036_arb_busy",  32'(bus.arb_busy),  0);
    model_reset();
    bs = 0; be = 0; fcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      step(4'b0000, d, 0);
      chk("r036_nosend", 32'(bus.tx_send), 0);
    end

`ifdef UART_TX_ARB_TAG_EN
    // tag + data pair is atomic; requester 1 waits for both bytes
    do_reset();
    repeat (6) step(4'b0100, d, -1);
    repeat (12) step(4'b0000, d, -1);
    g_log.delete(); s_log.delete();
    d = {8'h7E, 8'h00, 8'h11, 8'h00};
    repeat (25) step(4'b1010, d, -1);
    repeat (12) step(4'b0000, d, -1);
    chk("r037_g0", 32'(gl(0)), 3);
    chk("r037_g1", 32'(gl(1)), 1);
    chk("r037_s0", 32'(sl(0)), 32'hA3);
    chk("r037_s1", 32'(sl(1)), 32'h7E);
    chk("r037_s2", 32'(sl(2)), 32'hA1);
    chk("r037_s3", 32'(sl(3)), 32'h11);
`endif

    // randomized requesters, transmitter timing and foreign busy
    do_reset();
    s_log.delete();
    rand_uart = 1;
    foreign_en = 1;
    v = '0;
    d = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (s_acc && s_win == i) begin
          v[i] = $urandom % 2;
          d[8*i +: 8] = 8'($urandom);
        end else if (v[i] && ($urandom % 40) == 0) begin
          v[i] = 1'b0;
        end else if (!v[i] && ($urandom % 4) == 0) begin
          v[i] = 1'b1;
          d[8*i +: 8] = 8'($urandom);
        end
      end
      step(v, d, -1);
    end
    foreign_en = 0;
    repeat (30) step(4'b0000, d, -1);
    chk("rand_activity", 32'(s_log.size() > 100), 1);
    chk("rand_drained", 32'(bus.arb_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
